// File: rtl/log2_arbiter.sv
// Round-robin arbiter that shares one log2 unit between N_REQ requesters.
// Holds one transaction at a time: grant, launch, wait (with timeout), respond.
module log2_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         lg_int_in,
    output logic               lg_start,
    input  logic [7:0]         lg_result,
    input  logic               lg_zeroflag,
    input  logic               lg_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_id,
    output logic [7:0]         rsp_data,
    output logic               rsp_zero,
    output logic               rsp_err
);

    // state | meaning
    // IDLE  | waiting for a request; grants the round-robin winner
    // ISSUE | one-cycle lg_start pulse to the log2 unit
    // WAIT  | waiting for lg_ready, counting towards TIMEOUT
    // RESP  | response held on rsp_* until rsp_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] ID_LAST  = 3'(N_REQ - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  ptr;
    logic [7:0]  cnt;
    logic        grant_any;
    logic [2:0]  grant_idx;
    logic [7:0]  grant_op;

    // Search starts at the pointer and wraps, so the first hit is the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = 3'(idx);
            end
        end
    end

    assign grant_op = req_data[8*grant_idx +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = (grant_op == 8'd0) ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (lg_ready || (cnt == CNT_LAST)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && grant_any && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
        lg_start  = (state == ISSUE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            lg_int_in <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ptr    <= (grant_idx == ID_LAST) ? 3'd0 : grant_idx + 3'd1;
                        rsp_id <= grant_idx;
                        if (grant_op == 8'd0) begin
                            rsp_data <= '0;
                            rsp_zero <= 1'b1;
                            rsp_err  <= 1'b0;
                        end else begin
                            lg_int_in <= grant_op;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // lg_ready takes precedence over a timeout in the same cycle
                    if (lg_ready) begin
                        rsp_data <= lg_result;
                        rsp_zero <= lg_zeroflag;
                        rsp_err  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_log2_arbiter.sv
// Directed bench for log2_arbiter: round-robin order, latency, zero bypass,
// timeout boundary, backpressure and mid-transaction reset.
module tb_log2_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  lg_int_in;
    logic        lg_start;
    logic [7:0]  lg_result;
    logic        lg_zeroflag;
    logic        lg_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_zero;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    log2_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .lg_int_in   (lg_int_in),
        .lg_start    (lg_start),
        .lg_result   (lg_result),
        .lg_zeroflag (lg_zeroflag),
        .lg_ready    (lg_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at an IDLE negedge with req_valid/req_data already driven;
    // returns at the negedge where the response is first visible.
    task automatic txn(input int id, input logic [7:0] x, input int dly,
                       input logic [7:0] res, input logic drop);
        #1;
        check_val("grant", 32'(req_ready), 32'(1 << id));
        tick;
        if (drop) req_valid = 4'b0000;
        if (x == 8'd0) begin
            check_val("zero_no_start", 32'(lg_start), 32'd0);
            check_val("zero_rsp_valid", 32'(rsp_valid), 32'd1);
            check_val("zero_rsp_zero", 32'(rsp_zero), 32'd1);
            check_val("zero_rsp_err", 32'(rsp_err), 32'd0);
            check_val("zero_rsp_data", 32'(rsp_data), 32'd0);
        end else begin
            check_val("issue_start", 32'(lg_start), 32'd1);
            check_val("issue_operand", 32'(lg_int_in), 32'(x));
            check_val("issue_no_grant", 32'(req_ready), 32'd0);
            for (int i = 1; i <= dly; i++) begin
                tick;
                check_val("wait_start_low", 32'(lg_start), 32'd0);
                check_val("wait_no_rsp", 32'(rsp_valid), 32'd0);
                if (i == dly) begin
                    lg_ready = 1'b1;
                    lg_result = res;
                end
            end
            tick;
            lg_ready = 1'b0;
            lg_result = 8'd0;
            check_val("rsp_valid", 32'(rsp_valid), 32'd1);
            check_val("rsp_data", 32'(rsp_data), 32'(res));
            check_val("rsp_zero", 32'(rsp_zero), 32'd0);
            check_val("rsp_err", 32'(rsp_err), 32'd0);
        end
        check_val("rsp_id", 32'(rsp_id), 32'(id));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        lg_result = '0;
        lg_zeroflag = 1'b0;
        lg_ready = 1'b0;
        rsp_ready = 1'b1;
        tick;
        tick;
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_lg_start", 32'(lg_start), 32'd0);
        check_val("rst_lg_int_in", 32'(lg_int_in), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_fields", {rsp_id, rsp_data, rsp_zero, rsp_err}, 32'd0);
        rst_n = 1'b1;
        tick;

        // contention: all four held valid, expect 0,1,2,3,0
        req_data = {8'h08, 8'h04, 8'h02, 8'h01};
        req_valid = 4'hf;
        txn(0, 8'h01, 1, 8'h00, 1'b0); tick;
        txn(1, 8'h02, 2, 8'h20, 1'b0); tick;
        txn(2, 8'h04, 3, 8'h40, 1'b0); tick;
        txn(3, 8'h08, 1, 8'h60, 1'b0); tick;
        txn(0, 8'h01, 1, 8'h00, 1'b1); tick;

        // single request, lg_ready 5 cycles after lg_start
        req_data = {8'h00, 8'h00, 8'h00, 8'h08};
        req_valid = 4'b0001;
        txn(0, 8'h08, 5, 8'h60, 1'b1); tick;

        // zero bypass on requester 2; operand output keeps its last value
        req_data = {8'h00, 8'h00, 8'h00, 8'h00};
        req_valid = 4'b0100;
        txn(2, 8'h00, 0, 8'h00, 1'b1);
        check_val("zero_hold_operand", 32'(lg_int_in), 32'h08);
        tick;

        // timeout: 16 WAIT cycles with no lg_ready
        req_data = {8'h00, 8'h00, 8'h10, 8'h00};
        req_valid = 4'b0010;
        #1;
        check_val("to_grant", 32'(req_ready), 32'b0010);
        tick;
        req_valid = 4'b0000;
        check_val("to_start", 32'(lg_start), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick;
            check_val("to_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check_val("to_operand_hold", 32'(lg_int_in), 32'h10);
        tick;
        check_val("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("to_rsp_err", 32'(rsp_err), 32'd1);
        check_val("to_rsp_data", 32'(rsp_data), 32'd0);
        check_val("to_rsp_id", 32'(rsp_id), 32'd1);
        tick;

        // lg_ready on the 16th WAIT cycle wins over the timeout
        req_valid = 4'b0010;
        txn(1, 8'h10, 16, 8'h7f, 1'b1); tick;

        // backpressure: 10 cycles of rsp_ready low with all requests pending
        req_data = {8'h20, 8'h00, 8'h00, 8'h00};
        req_valid = 4'b1000;
        txn(3, 8'h20, 2, 8'h20, 1'b1);
        rsp_ready = 1'b0;
        req_valid = 4'hf;
        for (int i = 0; i < 10; i++) begin
            tick;
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_fields", {rsp_id, rsp_data, rsp_zero, rsp_err}, {3'd3, 8'h20, 1'b0, 1'b0});
            check_val("bp_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        check_val("bp_released", 32'(rsp_valid), 32'd0);
        check_val("bp_idle_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick;

        // reset in the middle of WAIT on requester 2
        req_data = {8'h00, 8'h05, 8'h00, 8'h00};
        req_valid = 4'b0100;
        #1;
        check_val("mr_grant", 32'(req_ready), 32'b0100);
        tick;
        req_valid = 4'b0000;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        check_val("mr_outputs", {req_ready, lg_start, lg_int_in, rsp_valid}, 32'd0);
        check_val("mr_rsp_fields", {rsp_id, rsp_data, rsp_zero, rsp_err}, 32'd0);
        rst_n = 1'b1;
        lg_ready = 1'b1;
        lg_result = 8'h55;
        tick;
        lg_ready = 1'b0;
        lg_result = 8'h00;
        check_val("mr_late_ready_ignored", 32'(rsp_valid), 32'd0);
        check_val("mr_no_start", 32'(lg_start), 32'd0);
        tick;
        check_val("mr_still_idle", 32'(rsp_valid), 32'd0);
        req_valid = 4'hf;
        #1;
        check_val("mr_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
